// File: rtl/ysyx_040066_mem_arbiter.sv
// Arbitrates the icache refill, dcache read and dcache writeback channels onto one memory port.
// Optional watchdog on stalled transactions: define YSYX_040066_ARB_TIMEOUT_EN.
module ysyx_040066_mem_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int LINE_W         = 512,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_req,
  input  logic              ins_burst,
  input  logic [ADDR_W-1:0] ins_addr,
  output logic              ins_ready,
  output logic              ins_err,
  output logic [LINE_W-1:0] ins_data,
  input  logic              rd_req,
  input  logic              rd_burst,
  input  logic [2:0]        rd_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_err,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic              wr_burst,
  input  logic [2:0]        wr_len,
  input  logic [7:0]        wr_mask,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_err,
  output logic              mem_req,
  output logic              mem_wr,
  output logic              mem_burst,
  output logic [2:0]        mem_len,
  output logic [7:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_err,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_INS  = 2'd1;
  localparam logic [1:0] G_RD   = 2'd2;
  localparam logic [1:0] G_WR   = 2'd3;

  state_t     state_q, state_d;
  logic       side_q;
  logic       err_q;
  logic       any_req;
  logic [1:0] win;
  logic       mem_done;
  logic       timed_out;
  logic       finish;

  assign any_req  = ins_req | rd_req | wr_req;
  assign mem_done = mem_ready | mem_err;
  assign finish   = mem_done | timed_out;

`ifdef YSYX_040066_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
  logic [CNT_W-1:0] cnt_q;

  // Cleared while idle so every BUSY entry starts counting from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt_q <= '0;
    else if (state_q == S_BUSY) cnt_q <= cnt_q + 1'b1;
    else                      cnt_q <= '0;
  end

  assign timed_out = (state_q == S_BUSY) && (cnt_q >= CNT_W'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timed_out = 1'b0;
`endif

  // Writeback beats refill on the dcache side; the side flag breaks icache/dcache ties.
  always_comb begin
    win = G_NONE;
    if (ins_req && (!(wr_req || rd_req) || !side_q)) win = G_INS;
    else if (wr_req)                                  win = G_WR;
    else if (rd_req)                                  win = G_RD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_BUSY;
      S_BUSY:  if (finish)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == S_BUSY);
    busy      = (state_q != S_IDLE);
    ins_ready = (state_q == S_DONE) && (grant == G_INS);
    rd_ready  = (state_q == S_DONE) && (grant == G_RD);
    wr_ready  = (state_q == S_DONE) && (grant == G_WR);
    ins_err   = ins_ready & err_q;
    rd_err    = rd_ready & err_q;
    wr_err    = wr_ready & err_q;
  end

  // Latches the winner's request and captures the response for its owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant     <= G_NONE;
      side_q    <= 1'b0;
      err_q     <= 1'b0;
      mem_wr    <= 1'b0;
      mem_burst <= 1'b0;
      mem_len   <= 3'd0;
      mem_mask  <= 8'h00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ins_data  <= '0;
      rd_data   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (any_req) begin
          grant <= win;
          case (win)
            G_WR: begin
              mem_wr    <= 1'b1;
              mem_burst <= wr_burst;
              mem_len   <= wr_len;
              mem_mask  <= wr_mask;
              mem_addr  <= wr_addr;
              mem_wdata <= wr_data;
            end
            G_RD: begin
              mem_wr    <= 1'b0;
              mem_burst <= rd_burst;
              mem_len   <= rd_len;
              mem_mask  <= 8'hFF;
              mem_addr  <= rd_addr;
              mem_wdata <= '0;
            end
            default: begin
              mem_wr    <= 1'b0;
              mem_burst <= ins_burst;
              mem_len   <= 3'd0;
              mem_mask  <= 8'hFF;
              mem_addr  <= ins_addr;
              mem_wdata <= '0;
            end
          endcase
        end
        S_BUSY: if (finish) begin
          err_q <= mem_done ? mem_err : 1'b1;
          if (mem_done && grant == G_INS) ins_data <= mem_rdata;
          if (mem_done && grant == G_RD)  rd_data  <= mem_rdata;
        end
        S_DONE: begin
          side_q <= (grant == G_INS);
          grant  <= G_NONE;
        end
        default: ;
      endcase
    end
  end

endmodule
